// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } grant_t;

  localparam logic [1:0] INSTR_BYTESEL = 2'b11;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master (data, instruction) to one-slave bus arbiter, one transaction per grant.
// Optional MEM_ARB_FAIR_EN: alternate grants so a continuously requesting data master cannot starve fetches.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W:1]   d_m_addr,
  input  logic [DATA_W-1:0] d_m_data_out,
  output logic [DATA_W-1:0] d_m_data_in,
  input  logic              d_m_access,
  output logic              d_m_ack,
  input  logic              d_m_wr_en,
  input  logic [1:0]        d_m_bytesel,
  input  logic [ADDR_W:1]   i_m_addr,
  output logic [DATA_W-1:0] i_m_data_in,
  input  logic              i_m_access,
  output logic              i_m_ack,
  output logic [ADDR_W:1]   q_m_addr,
  output logic [DATA_W-1:0] q_m_data_out,
  input  logic [DATA_W-1:0] q_m_data_in,
  output logic              q_m_access,
  input  logic              q_m_ack,
  output logic              q_m_wr_en,
  output logic [1:0]        q_m_bytesel
);

  grant_t grant;
  logic   prefer_i;

`ifdef MEM_ARB_FAIR_EN
  logic last_was_d;
  logic d_pair;

  // The second half of an unaligned pair is never deferred behind a fetch.
  assign prefer_i = last_was_d & ~d_pair;
`else
  assign prefer_i = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant <= IDLE;
`ifdef MEM_ARB_FAIR_EN
      last_was_d <= 1'b0;
      d_pair     <= 1'b0;
`endif
    end else begin
      case (grant)
        IDLE: begin
          if (d_m_access && i_m_access)
            grant <= prefer_i ? GNT_I : GNT_D;
          else if (d_m_access)
            grant <= GNT_D;
          else if (i_m_access)
            grant <= GNT_I;
        end
        GNT_D, GNT_I: begin
          if (q_m_ack)
            grant <= IDLE;
        end
        default: grant <= IDLE;
      endcase
`ifdef MEM_ARB_FAIR_EN
      if (q_m_ack && grant == GNT_D) begin
        last_was_d <= 1'b1;
        d_pair     <= ~d_pair & d_m_access;
      end else if (q_m_ack && grant == GNT_I) begin
        last_was_d <= 1'b0;
      end
`endif
    end
  end

  always_comb begin
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = '0;
    case (grant)
      GNT_D: begin
        q_m_addr     = d_m_addr;
        q_m_data_out = d_m_data_out;
        q_m_wr_en    = d_m_wr_en;
        q_m_bytesel  = d_m_bytesel;
      end
      GNT_I: begin
        q_m_addr    = i_m_addr;
        q_m_bytesel = INSTR_BYTESEL;
      end
      default: ;
    endcase
  end

  // Once granted the request is held regardless of the master, so a started transaction completes.
  assign q_m_access  = (grant != IDLE) && !q_m_ack;
  assign d_m_ack     = q_m_ack && (grant == GNT_D);
  assign i_m_ack     = q_m_ack && (grant == GNT_I);
  assign d_m_data_in = q_m_data_in;
  assign i_m_data_in = q_m_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then a randomized run
// checked every cycle against a transaction-level reference model (MEM_ARB_FAIR_EN aware).
module tb_mem_arbiter;

`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [19:1] d_m_addr, i_m_addr, q_m_addr;
  logic [15:0] d_m_data_out, d_m_data_in, i_m_data_in, q_m_data_out, q_m_data_in;
  logic        d_m_access, d_m_ack, d_m_wr_en;
  logic [1:0]  d_m_bytesel, q_m_bytesel;
  logic        i_m_access, i_m_ack;
  logic        q_m_access, q_m_ack, q_m_wr_en;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(19), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .d_m_addr(d_m_addr), .d_m_data_out(d_m_data_out), .d_m_data_in(d_m_data_in),
    .d_m_access(d_m_access), .d_m_ack(d_m_ack), .d_m_wr_en(d_m_wr_en), .d_m_bytesel(d_m_bytesel),
    .i_m_addr(i_m_addr), .i_m_data_in(i_m_data_in), .i_m_access(i_m_access), .i_m_ack(i_m_ack),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_data_in(q_m_data_in),
    .q_m_access(q_m_access), .q_m_ack(q_m_ack), .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: who currently owns the bus (0 none, 1 data, 2 instruction) plus fairness history.
  int m_owner = 0;
  bit m_last_d = 1'b0;
  bit m_pair = 1'b0;

  logic        o_qacc, o_dack, o_iack, o_wr;
  logic [19:1] o_addr;
  logic [15:0] o_qdout, o_idata, o_ddata;
  logic [1:0]  o_bsel;
  string       order;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit d, input bit i, input bit a);
    d_m_access = d;
    i_m_access = i;
    q_m_ack    = a;
  endtask

  // One bus cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic        e_acc, e_wr;
    logic [19:1] e_addr;
    logic [15:0] e_dout;
    logic [1:0]  e_bsel;
    @(negedge clk);
    e_acc = (m_owner != 0) && !q_m_ack;
    if (m_owner == 1) begin
      e_addr = d_m_addr; e_dout = d_m_data_out; e_wr = d_m_wr_en; e_bsel = d_m_bytesel;
    end else if (m_owner == 2) begin
      e_addr = i_m_addr; e_dout = 16'h0; e_wr = 1'b0; e_bsel = 2'b11;
    end else begin
      e_addr = '0; e_dout = 16'h0; e_wr = 1'b0; e_bsel = 2'b00;
    end
    check("q_m_access",   {31'b0, q_m_access}, {31'b0, e_acc});
    check("q_m_addr",     {13'b0, q_m_addr}, {13'b0, e_addr});
    check("q_m_data_out", {16'b0, q_m_data_out}, {16'b0, e_dout});
    check("q_m_wr_en",    {31'b0, q_m_wr_en}, {31'b0, e_wr});
    check("q_m_bytesel",  {30'b0, q_m_bytesel}, {30'b0, e_bsel});
    check("d_m_ack",      {31'b0, d_m_ack}, {31'b0, q_m_ack && m_owner == 1});
    check("i_m_ack",      {31'b0, i_m_ack}, {31'b0, q_m_ack && m_owner == 2});
    check("d_m_data_in",  {16'b0, d_m_data_in}, {16'b0, q_m_data_in});
    check("i_m_data_in",  {16'b0, i_m_data_in}, {16'b0, q_m_data_in});
    o_qacc = q_m_access; o_dack = d_m_ack; o_iack = i_m_ack; o_wr = q_m_wr_en;
    o_addr = q_m_addr; o_qdout = q_m_data_out; o_bsel = q_m_bytesel;
    o_idata = i_m_data_in; o_ddata = d_m_data_in;
    if (d_m_ack) order = {order, "D"};
    if (i_m_ack) order = {order, "I"};
    @(posedge clk);
    if (!reset) begin
      m_owner = 0; m_last_d = 1'b0; m_pair = 1'b0;
    end else if (m_owner == 0) begin
      if (d_m_access && i_m_access)
        m_owner = (FAIR && m_last_d && !m_pair) ? 2 : 1;
      else if (d_m_access)
        m_owner = 1;
      else if (i_m_access)
        m_owner = 2;
    end else if (q_m_ack) begin
      if (m_owner == 1) begin
        m_pair   = !m_pair && d_m_access;
        m_last_d = 1'b1;
      end else begin
        m_last_d = 1'b0;
      end
      m_owner = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 0, 0);
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0);
    d_m_addr = '0; d_m_data_out = '0; d_m_wr_en = 1'b0; d_m_bytesel = 2'b00;
    i_m_addr = '0; q_m_data_in = '0;
    order = "";
    @(posedge clk);
    #1;

    // Reset state
    step();
    check("rst_qacc", {31'b0, o_qacc}, 32'd0);
    check("rst_addr", {13'b0, o_addr}, 32'd0);
    check("rst_acks", {30'b0, o_dack, o_iack}, 32'd0);
    reset = 1'b1;

    // Single data write with two wait states
    d_m_addr = 19'h01234; d_m_data_out = 16'hBEEF; d_m_bytesel = 2'b01; d_m_wr_en = 1'b1;
    order = "";
    drive(1, 0, 0); step();
    check("wr_arb_qacc", {31'b0, o_qacc}, 32'd0);
    step();
    check("wr_qacc", {31'b0, o_qacc}, 32'd1);
    check("wr_addr", {13'b0, o_addr}, 32'h01234);
    check("wr_data", {16'b0, o_qdout}, 32'hBEEF);
    check("wr_bsel", {30'b0, o_bsel}, 32'd1);
    check("wr_wren", {31'b0, o_wr}, 32'd1);
    step();
    drive(1, 0, 1); step();
    check("wr_dack", {31'b0, o_dack}, 32'd1);
    check("wr_iack", {31'b0, o_iack}, 32'd0);
    drive(0, 0, 0); step();
    check("wr_idle_qacc", {31'b0, o_qacc}, 32'd0);
    step();
    check("wr_one_ack", {31'b0, order == "D"}, 32'd1);
    d_m_wr_en = 1'b0;

    // Simultaneous requests, zero-wait slave
    do_reset();
    order = ""; d_m_addr = 19'h00100; i_m_addr = 19'h00400;
    drive(1, 1, 0); step();
    q_m_data_in = 16'hAAAA; drive(0, 1, 1); step();
    check("sim_dack", {31'b0, o_dack}, 32'd1);
    check("sim_no_iack", {31'b0, o_iack}, 32'd0);
    q_m_data_in = 16'h1234; drive(0, 1, 0); step();
    drive(0, 1, 1); step();
    check("sim_iack", {31'b0, o_iack}, 32'd1);
    check("sim_idata", {16'b0, o_idata}, 32'h1234);
    drive(0, 0, 0); step(); step();
    check("sim_order", {31'b0, order == "DI"}, 32'd1);

    // Unaligned pair with instruction request pending throughout
    do_reset();
    order = "";
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, k % 2 == 1);
      step();
    end
    drive(0, 0, 0); step();
    check("pair_order", {31'b0, order == (FAIR ? "DDI" : "DDD")}, 32'd1);

    // Reset while granted to the instruction master; late slave ack is discarded
    do_reset();
    order = ""; i_m_addr = 19'h00777; d_m_addr = 19'h05555;
    drive(0, 1, 0); step();
    reset = 1'b0; step();
    check("rst_mid_qacc", {31'b0, o_qacc}, 32'd1);
    reset = 1'b1; drive(0, 0, 1); step();
    check("rst_late_iack", {31'b0, o_iack}, 32'd0);
    check("rst_late_qacc", {31'b0, o_qacc}, 32'd0);
    drive(1, 0, 0); step();
    check("rst_rearb_qacc", {31'b0, o_qacc}, 32'd0);
    step();
    check("rst_next_qacc", {31'b0, o_qacc}, 32'd1);
    check("rst_next_addr", {13'b0, o_addr}, 32'h05555);
    drive(0, 0, 1); step();
    check("rst_next_dack", {31'b0, o_dack}, 32'd1);
    drive(0, 0, 0); step();

    // Data master drops its request after being granted
    do_reset();
    drive(1, 0, 0); step();
    drive(0, 0, 0); step();
    check("drop_qacc1", {31'b0, o_qacc}, 32'd1);
    step();
    check("drop_qacc2", {31'b0, o_qacc}, 32'd1);
    drive(0, 0, 1); step();
    check("drop_dack", {31'b0, o_dack}, 32'd1);
    check("drop_ack_qacc", {31'b0, o_qacc}, 32'd0);
    drive(0, 0, 0); step();
    check("drop_idle_qacc", {31'b0, o_qacc}, 32'd0);

    // Both masters streaming aligned reads: data drops its request in each ack cycle
    do_reset();
    order = "";
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 1) drive(0, 1, 1);
      else drive(1, 1, 0);
      step();
    end
    drive(0, 0, 0); step();
    check("stream_order", {31'b0, order == (FAIR ? "DIDIDIDI" : "DDDDDDDD")}, 32'd1);

    // Randomized traffic, including acks in idle and occasional resets
    for (int k = 0; k < 4000; k++) begin
      reset = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 3) == 0) d_m_access = ~d_m_access;
      if ($urandom_range(0, 3) == 0) i_m_access = ~i_m_access;
      if ($urandom_range(0, 3) == 0) begin
        d_m_addr     = 19'($urandom);
        d_m_data_out = 16'($urandom);
        d_m_wr_en    = 1'($urandom);
        d_m_bytesel  = 2'($urandom);
      end
      if ($urandom_range(0, 3) == 0) i_m_addr = 19'($urandom);
      q_m_ack     = ($urandom_range(0, 2) == 0);
      q_m_data_in = 16'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
